// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants, ALU op codes and the decoded control bundle
// handed from the decode stage to execute.
package rv32i_pkg;

    localparam int REG_WIDTH = 32;

    typedef enum logic [5:0] {
        OP_ALU_ADD  = 6'd0,
        OP_ALU_SUB  = 6'd1,
        OP_ALU_SLL  = 6'd2,
        OP_ALU_SLT  = 6'd3,
        OP_ALU_SLTU = 6'd4,
        OP_ALU_XOR  = 6'd5,
        OP_ALU_SRL  = 6'd6,
        OP_ALU_SRA  = 6'd7,
        OP_ALU_OR   = 6'd8,
        OP_ALU_AND  = 6'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e                op;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic                   rd_we;
        logic                   a_sel_pc;
        logic                   b_sel_imm;
        logic [REG_WIDTH-1:0]   imm;
        logic [REG_WIDTH-1:0]   pc;
        logic                   illegal;
    } alu_ctrl_t;

    // alt selects SUB over ADD and SRA over SRL; it is ignored for other funct3 values.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? OP_ALU_SUB : OP_ALU_ADD;
            F3_SLL:     op = OP_ALU_SLL;
            F3_SLT:     op = OP_ALU_SLT;
            F3_SLTU:    op = OP_ALU_SLTU;
            F3_XOR:     op = OP_ALU_XOR;
            F3_SRL_SRA: op = alt ? OP_ALU_SRA : OP_ALU_SRL;
            F3_OR:      op = OP_ALU_OR;
            default:    op = OP_ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Immediate extraction for ALU-class instructions: I-type, U-type and the
// zero-extended shift amount used by SLLI/SRLI/SRAI.
module alu_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0]          instr,
    output logic [REG_WIDTH-1:0] imm_i,
    output logic [REG_WIDTH-1:0] imm_u,
    output logic [REG_WIDTH-1:0] imm_shamt
);

    assign imm_i     = REG_WIDTH'($signed(instr[31:20]));
    assign imm_u     = REG_WIDTH'($signed({instr[31:12], 12'b0}));
    assign imm_shamt = REG_WIDTH'(instr[24:20]);

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode for ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) feeding a single
// registered valid/ready slot in front of execute.
module alu_decode_stage
    import rv32i_pkg::*;
#(
    parameter bit CHECK_FUNCT7 = 1'b1
)
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [REG_WIDTH-1:0] pc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [5:0]           op_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic                 rd_we_o,
    output logic                 a_sel_pc_o,
    output logic                 b_sel_imm_o,
    output logic [REG_WIDTH-1:0] imm_o,
    output logic [REG_WIDTH-1:0] pc_o,
    output logic                 illegal_o
);

    logic [REG_WIDTH-1:0] imm_i;
    logic [REG_WIDTH-1:0] imm_u;
    logic [REG_WIDTH-1:0] imm_shamt;
    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic                 legal;
    logic                 load;
    alu_ctrl_t            ctrl_p0;
    alu_ctrl_t            ctrl_p1;
    logic                 vld_p1;

    alu_imm_gen u_imm_gen (
        .instr     (instr_i),
        .imm_i     (imm_i),
        .imm_u     (imm_u),
        .imm_shamt (imm_shamt)
    );

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    // Stage p0: combinational decode of the incoming instruction
    always_comb begin
        legal             = 1'b0;
        ctrl_p0           = '0;
        ctrl_p0.op        = OP_ALU_ADD;
        ctrl_p0.rs1       = instr_i[19:15];
        ctrl_p0.rs2       = instr_i[24:20];
        ctrl_p0.rd        = instr_i[11:7];
        ctrl_p0.pc        = pc_i;

        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
                    legal = 1'b1;
                end else begin
                    legal = !CHECK_FUNCT7;
                end
                ctrl_p0.op = f3_to_op(f3, instr_i[30]);
            end
            OPC_OP_IMM: begin
                legal             = 1'b1;
                ctrl_p0.b_sel_imm = 1'b1;
                ctrl_p0.imm       = imm_i;
                // Only shifts take instr[30] as an opcode bit; elsewhere it is immediate.
                ctrl_p0.op        = f3_to_op(f3, (f3 == F3_SRL_SRA) && instr_i[30]);
                if (f3 == F3_SLL) begin
                    ctrl_p0.imm = imm_shamt;
                    if (CHECK_FUNCT7 && f7 != F7_BASE) legal = 1'b0;
                end else if (f3 == F3_SRL_SRA) begin
                    ctrl_p0.imm = imm_shamt;
                    if (CHECK_FUNCT7 && f7 != (instr_i[30] ? F7_ALT : F7_BASE)) legal = 1'b0;
                end
            end
            OPC_LUI: begin
                legal             = 1'b1;
                ctrl_p0.rs1       = 5'd0;
                ctrl_p0.b_sel_imm = 1'b1;
                ctrl_p0.imm       = imm_u;
            end
            OPC_AUIPC: begin
                legal             = 1'b1;
                ctrl_p0.a_sel_pc  = 1'b1;
                ctrl_p0.b_sel_imm = 1'b1;
                ctrl_p0.imm       = imm_u;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl_p0.op        = OP_ALU_ADD;
            ctrl_p0.a_sel_pc  = 1'b0;
            ctrl_p0.b_sel_imm = 1'b0;
            ctrl_p0.imm       = '0;
        end
        ctrl_p0.illegal = !legal;
        ctrl_p0.rd_we   = legal && (ctrl_p0.rd != 5'd0);
    end

    assign in_ready_o = !vld_p1 || out_ready_i;
    assign load       = in_valid_i && in_ready_o && !flush_i;

    // Stage p1: output slot; flush takes priority over a load in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (flush_i) begin
            vld_p1  <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= ctrl_p0;
        end else if (out_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid_o = vld_p1;
    assign op_o        = ctrl_p1.op;
    assign rs1_o       = ctrl_p1.rs1;
    assign rs2_o       = ctrl_p1.rs2;
    assign rd_o        = ctrl_p1.rd;
    assign rd_we_o     = ctrl_p1.rd_we;
    assign a_sel_pc_o  = ctrl_p1.a_sel_pc;
    assign b_sel_imm_o = ctrl_p1.b_sel_imm;
    assign imm_o       = ctrl_p1.imm;
    assign pc_o        = ctrl_p1.pc;
    assign illegal_o   = ctrl_p1.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed RV32I encodings and handshake
// corner cases, then randomized traffic against a behavioural decode model.
module tb_alu_decode_stage;
    import rv32i_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  op_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic        a_sel_pc_o;
    logic        b_sel_imm_o;
    logic [31:0] imm_o;
    logic [31:0] pc_o;
    logic        illegal_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic exp_valid = 1'b0;

    alu_decode_stage dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .op_o        (op_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .rd_o        (rd_o),
        .rd_we_o     (rd_we_o),
        .a_sel_pc_o  (a_sel_pc_o),
        .b_sel_imm_o (b_sel_imm_o),
        .imm_o       (imm_o),
        .pc_o        (pc_o),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t        e;
        logic [6:0]  opc   = ins[6:0];
        logic [2:0]  f3    = ins[14:12];
        logic [6:0]  f7    = ins[31:25];
        logic [31:0] imm_i = 32'($signed(ins) >>> 20);
        logic [31:0] imm_u = ins & 32'hFFFF_F000;
        logic [31:0] sh    = (ins >> 20) & 32'h1F;
        logic [5:0]  base_op [8] = '{OP_ALU_ADD, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
                                     OP_ALU_XOR, OP_ALU_SRL, OP_ALU_OR, OP_ALU_AND};
        logic        legal = 1'b0;
        e.op = OP_ALU_ADD; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.a_sel = 1'b0; e.b_sel = 1'b0; e.imm = 32'd0; e.pc = p;
        if (opc == 7'b0110011) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.op  = base_op[f3];
            if (f7 == 7'h20 && f3 == 3'd0) e.op = OP_ALU_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) e.op = OP_ALU_SRA;
        end else if (opc == 7'b0010011) begin
            e.b_sel = 1'b1;
            if (f3 == 3'd1) begin
                legal = (f7 == 7'h00); e.imm = sh; e.op = OP_ALU_SLL;
            end else if (f3 == 3'd5) begin
                e.imm = sh;
                if (f7 == 7'h00) begin legal = 1'b1; e.op = OP_ALU_SRL; end
                else if (f7 == 7'h20) begin legal = 1'b1; e.op = OP_ALU_SRA; end
            end else begin
                legal = 1'b1; e.imm = imm_i; e.op = base_op[f3];
            end
        end else if (opc == 7'b0110111) begin
            legal = 1'b1; e.rs1 = 5'd0; e.b_sel = 1'b1; e.imm = imm_u;
        end else if (opc == 7'b0010111) begin
            legal = 1'b1; e.a_sel = 1'b1; e.b_sel = 1'b1; e.imm = imm_u;
        end
        if (!legal) begin
            e.op = OP_ALU_ADD; e.a_sel = 1'b0; e.b_sel = 1'b0; e.imm = 32'd0;
        end
        e.illegal = !legal;
        e.rd_we   = legal && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic cmp_bundle(input exp_t e);
        chk("op", 32'(op_o), 32'(e.op));
        chk("rs1", 32'(rs1_o), 32'(e.rs1));
        chk("rs2", 32'(rs2_o), 32'(e.rs2));
        chk("rd", 32'(rd_o), 32'(e.rd));
        chk("rd_we", 32'(rd_we_o), 32'(e.rd_we));
        chk("a_sel_pc", 32'(a_sel_pc_o), 32'(e.a_sel));
        chk("b_sel_imm", 32'(b_sel_imm_o), 32'(e.b_sel));
        chk("imm", imm_o, e.imm);
        chk("pc", pc_o, e.pc);
        chk("illegal", 32'(illegal_o), 32'(e.illegal));
    endtask

    // Monitor: compares the presented bundle every cycle and retires it on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni && out_valid_o) begin
                if (out_ready_i) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_bundle got=valid expected=none at %0t", $time);
                    end else begin
                        cmp_bundle(sbq.pop_front());
                    end
                end else if (!flush_i && sbq.size() != 0) begin
                    cmp_bundle(sbq[0]);
                end
            end
        end
    end

    // One cycle of stimulus; the model state is advanced for the coming edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid_o), 32'(exp_valid));
        #1;
        in_valid_i = v; instr_i = ins; pc_i = p; out_ready_i = ordy; flush_i = fl;
        #1;
        chk("in_ready", 32'(in_ready_o), 32'(!exp_valid || ordy));
        if (fl) begin
            if (exp_valid && !ordy) void'(sbq.pop_front());
            exp_valid = 1'b0;
        end else if (v && (!exp_valid || ordy)) begin
            sbq.push_back(model(ins, p));
            exp_valid = 1'b1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd   = 5'($urandom);
        logic [4:0]  rs1  = 5'($urandom);
        logic [4:0]  rs2  = 5'($urandom);
        logic [2:0]  f3   = 3'($urandom);
        logic [6:0]  f7   = 7'($urandom);
        logic [31:0] word = $urandom;
        case ($urandom_range(0, 6))
            0: return {($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20, rs2, rs1, f3, rd, OPC_OP};
            1: return {word[31:20], rs1, f3, rd, OPC_OP_IMM};
            2: return {($urandom_range(0, 2) == 0) ? f7 : (($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20),
                       rs2, rs1, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, rd, OPC_OP_IMM};
            3: return {word[31:12], rd, OPC_LUI};
            4: return {word[31:12], rd, OPC_AUIPC};
            5: return {f7, rs2, rs1, f3, rd, OPC_OP};
            default: return word;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam int NDIR = 9;
    logic [31:0] dir_ins [NDIR] = '{32'h002081B3, 32'h402081B3, 32'h422081B3, 32'hFFF00293,
                                    32'h4033D313, 32'h123450B7, 32'h00001097, 32'h00000000,
                                    32'h00100013};
    logic [31:0] dir_pc  [NDIR] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100,
                                    32'h18, 32'h1C};

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instr_i = 32'd0; pc_i = 32'd0;
        #12;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_op", 32'(op_o), 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        @(posedge clk); #2; rst_ni = 1'b1;

        for (int i = 0; i < NDIR; i++) cycle(1'b1, dir_ins[i], dir_pc[i], 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Backpressure: two instructions against a stalled consumer, then release.
        cycle(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081B3, 32'h204, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        // Flush during stall drops the held bundle; flush also beats a load.
        cycle(1'b1, 32'hFFF00293, 32'h208, 1'b0, 1'b1);
        cycle(1'b1, 32'h4033D313, 32'h20C, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        // Asynchronous reset while a bundle is held.
        cycle(1'b1, 32'h123450B7, 32'h210, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        chk("reset_mid_stall_valid", 32'(out_valid_o), 32'd0);
        sbq.delete();
        exp_valid = 1'b0;
        @(posedge clk); #2; rst_ni = 1'b1;
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cycle(1'b1 && ($urandom_range(0, 3) != 0), gen_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
